cpu_prefetch: RTL and testbench
===============================

# cpu_prefetch

Instruction prefetch queue between the external byte memory bus and the x86 core's opcode/ModRM/immediate fetch path. It autonomously fetches sequential code bytes from a 20-bit linear address into a DEPTH-byte FIFO. The core consumes bytes from the head and redirects the stream with `flush` on any IP change (jump, call, interrupt, segment load). Memory access is one outstanding byte at a time over a req/ack handshake; the core's data accesses are arbitrated outside this block.

## Interface
- `DEPTH`, 8: queue size in bytes; power of two, 4..16.
- `RESET_ADDR`, 20'hFFFF0: linear fetch address after reset.
- `clock`  in  1  system clock (25 MHz); all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `flush`  in  1  discard queue, restart fetching at `flush_addr`.
- `flush_addr`  in  20  new linear fetch address; sampled when `flush`=1.
- `q_data`  out  8  head byte; valid when `q_valid`.
- `q_valid`  out  1  queue non-empty.
- `q_take`  in  1  pop head; ignored when `q_valid`=0 or `flush`=1.
- `q_addr`  out  20  linear address of head byte, or the next fetch address when empty.
- `q_level`  out  $clog2(DEPTH)+1  bytes held.
- `mem_req`  out  1  read request.
- `mem_addr`  out  20  read address; stable while `mem_req`=1 until ack.
- `mem_ack`  in  1  request complete; `mem_data` is valid in this cycle.
- `mem_data`  in  8  read data.

## Operation
- **FSM states:**
  - **FETCH:** `mem_req`=1 while a slot is free.
  - **WAIT_SLOT:** queue full, `mem_req`=0.
  - **DRAIN:** an old-stream request is still outstanding after a flush.
- **Free-slot rule:** a request is issued or held when `q_level` + (ack this cycle ? 1 : 0) − (take this cycle ? 1 : 0) < DEPTH after the edge. One outstanding request at most.
- **Ack in FETCH:** write `mem_data` at the tail. `mem_addr` ← `mem_addr`+1, wrapping 20'hFFFFF→20'h00000. Keep `mem_req` high if the free-slot rule holds, else go to WAIT_SLOT.
- **WAIT_SLOT:** on take, return to FETCH.
- **Take:** advances the head and increments `q_addr` with 20-bit wrap.
- **Flush with no request outstanding** (WAIT_SLOT, or FETCH with `mem_req` low): queue emptied. `mem_addr` and `q_addr` ← `flush_addr`. Go to FETCH.
- **Flush with request outstanding and no ack this cycle:** the queue is emptied and the target is latched in `pend_addr`. Go to DRAIN; `mem_req` and `mem_addr` keep the old values, because the bus cannot abort.
- **Flush and ack in the same cycle:** the ack data is discarded. Go directly to FETCH at `flush_addr`.
- **DRAIN:**
  - On ack, discard the data, load `mem_addr` ← `pend_addr`, go to FETCH.
  - A further flush in DRAIN overwrites `pend_addr` and stays in DRAIN.
  - `q_valid`=0 throughout DRAIN.
- **Simultaneous events:** flush outranks take and ack-write. Take and ack in the same cycle keep the level unchanged and are legal at any level.
- **Address width:** wrap is purely 20-bit linear; CS 64 KiB wrap is the core's responsibility (via flush).

## Timing
- **Reset values:** `q_valid`=0, `q_level`=0, `q_data`=0, `mem_req`=0, `mem_addr`=`RESET_ADDR`, `q_addr`=`RESET_ADDR`, state FETCH.
- **First request:** `mem_req` rises on the first posedge after `reset` deasserts.
- **Fill latency:** an ack in cycle N gives `q_valid`=1 and the byte on `q_data` in cycle N+1 (registered).
- **Throughput:** with `mem_ack` tied high, one byte per cycle (back-to-back requests).
- **Flush latency:** flush in cycle N gives `q_valid`=0 and `q_addr`=`flush_addr` in N+1. A new-address request appears in N+1, or the cycle after the draining ack.
- **Reset mid-request:** the outstanding request is abandoned. The memory side must tolerate `mem_req` dropping asynchronously.
- **Registered outputs:** `q_data`, `q_valid`, `q_addr`, `q_level`, `mem_req`, `mem_addr`. No combinational path from `q_take` to `mem_req`.

## Structure
- **Shared package `cpu_pkg`:** state encoding (FETCH, WAIT_SLOT, DRAIN), default `RESET_ADDR`, `LIN_W`=20.
- **Sub-module `prefetch_fifo`:** DEPTH×8 circular buffer with head/tail pointers, count, synchronous clear, simultaneous push/pop. Registered head output.
- **Top level:** FSM, address counters, `pend_addr`, free-slot logic.

## Test plan
- **Reset fetch:** release reset, `mem_ack`=1 always, `mem_data`=addr[7:0] → `mem_addr` FFFF0, FFFF1, ... with no bubbles. After 8 cycles and no takes: `q_level`=8, `mem_req`=0. `q_data`=F0, `q_addr`=FFFF0.
- **Steady stream:** take every cycle with `mem_ack` tied high → bytes F0,F1,... in order, no gaps, `q_level` stays constant. Stream crosses FFFFF→00000 correctly.
- **Flush while idle-full:** full queue, flush to 12345 → next cycle `q_valid`=0, `q_addr`=12345, `mem_req`=1, `mem_addr`=12345. First byte delivered is 45.
- **Flush mid-request:** ack withheld 3 cycles, flush to 00100 in cycle 1 and 00200 in cycle 2 → old address held until ack, its data never queued. Next request is 00200.
- **Flush and ack together:** flush to 0ABCD in the ack cycle → acked byte dropped, `mem_addr`=0ABCD next cycle.
- **Random ack delays (0–5 cycles), random take/flush:** scoreboard checks every taken byte equals the memory model at `q_addr`, and `q_level` never exceeds DEPTH.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: linear address width, reset
// fetch address and prefetch state encoding.
package cpu_pkg;

    localparam int LIN_W = 20;

    localparam logic [LIN_W-1:0] RESET_ADDR_DEFAULT = 20'hFFFF0;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_DRAIN     = 2'd2
    } pf_state_t;

    // Next sequential linear address; wraps FFFFF -> 00000 by width.
    function automatic logic [LIN_W-1:0] lin_inc(input logic [LIN_W-1:0] a);
        return a + 1'b1;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Byte-wide circular buffer for the prefetch queue. Head byte, valid flag and
// count are all registered so the core sees clean outputs.
module prefetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    buf_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    head_data_q, head_data_d;
    logic          valid_q, valid_d;
    logic          pop_ok, push_ok, wr_en;

    // A pop on an empty queue or a push into a full queue without a matching
    // pop would corrupt the pointers, so both are masked here.
    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);

    // Next pointers, count and head byte; the pushed byte bypasses the array
    // when it becomes the head in the same cycle.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        head_data_d = head_data_q;
        valid_d     = valid_q;
        wr_en       = 1'b0;
        if (clr) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            head_data_d = 8'h00;
            valid_d     = 1'b0;
        end else begin
            if (push_ok) begin
                tail_d = tail_q + 1'b1;
                wr_en  = 1'b1;
            end
            if (pop_ok) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
            valid_d = (count_d != '0);
            if (push_ok && ((count_q - {{PW{1'b0}}, pop_ok}) == '0)) begin
                head_data_d = push_data;
            end else if (count_d != '0) begin
                head_data_d = buf_q[head_d];
            end
        end
    end

    // Control and head registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            head_data_q <= 8'h00;
            valid_q     <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            head_data_q <= head_data_d;
            valid_q     <= valid_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_q[tail_q] <= push_data;
        end
    end

    assign head_data = head_data_q;
    assign valid     = valid_q;
    assign count     = count_q;

endmodule

// File: rtl/cpu_prefetch.sv
// Instruction prefetch queue: fetches sequential code bytes one request at a
// time over a req/ack bus and redirects on flush. An outstanding request
// cannot be aborted, so a flush during one drains it before refetching.
module cpu_prefetch
    import cpu_pkg::*;
#(
    parameter int               DEPTH      = 8,
    parameter logic [LIN_W-1:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [LIN_W-1:0]         flush_addr,
    output logic [7:0]               q_data,
    output logic                     q_valid,
    input  logic                     q_take,
    output logic [LIN_W-1:0]         q_addr,
    output logic [$clog2(DEPTH):0]   q_level,
    output logic                     mem_req,
    output logic [LIN_W-1:0]         mem_addr,
    input  logic                     mem_ack,
    input  logic [7:0]               mem_data
);

    localparam int LW = $clog2(DEPTH) + 1;

    pf_state_t        state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic [LIN_W-1:0] mem_addr_q, mem_addr_d;
    logic [LIN_W-1:0] q_addr_q, q_addr_d;
    logic [LIN_W-1:0] pend_addr_q, pend_addr_d;

    logic             fifo_clr, fifo_push, fifo_pop;
    logic             ack_ok, take_ok;
    logic [LW-1:0]    lvl_next;

    // An ack only counts against a live request; flush outranks take.
    assign ack_ok  = mem_ack && mem_req_q;
    assign take_ok = q_take && q_valid && !flush;

    // Level after this edge if the ack is written and the take pops.
    assign lvl_next = q_level + {{(LW-1){1'b0}}, ack_ok} - {{(LW-1){1'b0}}, take_ok};

    // Next-state, address counters and queue control.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        q_addr_d    = q_addr_q;
        pend_addr_d = pend_addr_q;
        fifo_clr    = 1'b0;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;

        if (take_ok) begin
            fifo_pop = 1'b1;
            q_addr_d = lin_inc(q_addr_q);
        end

        case (state_q)
            ST_FETCH: begin
                if (flush) begin
                    fifo_clr = 1'b1;
                    q_addr_d = flush_addr;
                    if (mem_req_q && !ack_ok) begin
                        pend_addr_d = flush_addr;
                        state_d     = ST_DRAIN;
                    end else begin
                        mem_addr_d = flush_addr;
                        mem_req_d  = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end else begin
                    if (ack_ok) begin
                        fifo_push  = 1'b1;
                        mem_addr_d = lin_inc(mem_addr_q);
                    end
                    mem_req_d = (lvl_next < LW'(DEPTH));
                    state_d   = mem_req_d ? ST_FETCH : ST_WAIT_SLOT;
                end
            end
            ST_WAIT_SLOT: begin
                if (flush) begin
                    fifo_clr   = 1'b1;
                    q_addr_d   = flush_addr;
                    mem_addr_d = flush_addr;
                    mem_req_d  = 1'b1;
                    state_d    = ST_FETCH;
                end else if (take_ok) begin
                    mem_req_d = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    fifo_clr = 1'b1;
                    q_addr_d = flush_addr;
                    if (ack_ok) begin
                        mem_addr_d = flush_addr;
                        mem_req_d  = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        pend_addr_d = flush_addr;
                    end
                end else if (ack_ok) begin
                    mem_addr_d = pend_addr_q;
                    mem_req_d  = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d   = ST_FETCH;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered bus/address outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= RESET_ADDR;
            q_addr_q    <= RESET_ADDR;
            pend_addr_q <= RESET_ADDR;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            q_addr_q    <= q_addr_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clr       (fifo_clr),
        .push      (fifo_push),
        .push_data (mem_data),
        .pop       (fifo_pop),
        .head_data (q_data),
        .valid     (q_valid),
        .count     (q_level)
    );

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign q_addr   = q_addr_q;

endmodule

// File: tb/tb_cpu_prefetch.sv
// Self-checking bench for cpu_prefetch: directed scenarios plus a random
// ack-delay / take / flush run checked against a byte-memory model.
module tb_cpu_prefetch;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [19:0] flush_addr;
    logic [7:0]  q_data;
    logic        q_valid;
    logic        q_take;
    logic [19:0] q_addr;
    logic [3:0]  q_level;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;

    int total = 0;
    int bad   = 0;
    int ack_mode = 2;      // 0: ack tied high, 1: random delay, 2: manual
    bit mix_en = 1'b0;
    logic [7:0] sb[$];
    logic [19:0] exp_addr;

    cpu_prefetch #(.DEPTH(DEPTH), .RESET_ADDR(20'hFFFF0)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .flush_addr (flush_addr),
        .q_data     (q_data),
        .q_valid    (q_valid),
        .q_take     (q_take),
        .q_addr     (q_addr),
        .q_level    (q_level),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data)
    );

    always #20 clock = ~clock;

    function automatic logic [7:0] memf(input logic [19:0] a);
        return mix_en ? (a[7:0] ^ a[19:12]) : a[7:0];
    endfunction

    // Memory responder.
    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clock);
            if (ack_mode == 0) begin
                mem_ack  = 1'b1;
                mem_data = memf(mem_addr);
            end else if (ack_mode == 1) begin
                if (mem_req && wait_cnt == 0) begin
                    mem_ack  = 1'b1;
                    mem_data = memf(mem_addr);
                    wait_cnt = int'($urandom_range(0, 5));
                end else begin
                    mem_ack = 1'b0;
                    if (mem_req && wait_cnt > 0) wait_cnt--;
                end
            end
        end
    end

    initial begin : watchdog
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; flush_addr = '0; q_take = 1'b0;
        mem_ack = 1'b0; mem_data = 8'h00;
        step(); step();
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL rst_q_valid got=%h want=0", q_valid); end
        total++; if (q_level !== 4'd0) begin bad++; $display("FAIL rst_q_level got=%0d want=0", q_level); end
        total++; if (q_data !== 8'h00) begin bad++; $display("FAIL rst_q_data got=%h want=00", q_data); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%h want=0", mem_req); end
        total++; if (mem_addr !== 20'hFFFF0) begin bad++; $display("FAIL rst_mem_addr got=%h want=ffff0", mem_addr); end
        total++; if (q_addr !== 20'hFFFF0) begin bad++; $display("FAIL rst_q_addr got=%h want=ffff0", q_addr); end
        ack_mode = 0;
        reset = 1'b0;
    endtask

    task automatic test_reset_fetch();
        for (int i = 0; i < 8; i++) begin
            step();
            total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fill_req[%0d] got=%h want=1", i, mem_req); end
            total++; if (mem_addr !== 20'hFFFF0 + 20'(i)) begin bad++; $display("FAIL fill_addr[%0d] got=%h want=%h", i, mem_addr, 20'hFFFF0 + 20'(i)); end
            total++; if (q_level !== 4'(i)) begin bad++; $display("FAIL fill_level[%0d] got=%0d want=%0d", i, q_level, i); end
        end
        step();
        total++; if (q_level !== 4'd8) begin bad++; $display("FAIL full_level got=%0d want=8", q_level); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_req got=%h want=0", mem_req); end
        total++; if (q_data !== 8'hF0) begin bad++; $display("FAIL full_q_data got=%h want=f0", q_data); end
        total++; if (q_addr !== 20'hFFFF0) begin bad++; $display("FAIL full_q_addr got=%h want=ffff0", q_addr); end
        total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL full_q_valid got=%h want=1", q_valid); end
    endtask

    task automatic test_stream();
        logic [7:0] exp;
        exp_addr = 20'hFFFF0;
        for (int i = 0; i < 40; i++) begin
            sb.push_back(memf(exp_addr));
            exp = sb.pop_front();
            total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%h want=1", i, q_valid); end
            total++; if (q_data !== exp) begin bad++; $display("FAIL stream_data[%0d] got=%h want=%h", i, q_data, exp); end
            total++; if (q_addr !== exp_addr) begin bad++; $display("FAIL stream_addr[%0d] got=%h want=%h", i, q_addr, exp_addr); end
            if (i >= 1) begin
                total++; if (q_level !== 4'd7) begin bad++; $display("FAIL stream_level[%0d] got=%0d want=7", i, q_level); end
            end
            q_take = 1'b1;
            exp_addr = exp_addr + 20'd1;
            step();
        end
        q_take = 1'b0;
    endtask

    task automatic test_flush_idle();
        int n;
        n = 0;
        while (!(q_level == 4'd8 && mem_req == 1'b0) && n < 20) begin
            step();
            n++;
        end
        total++; if (n >= 20) begin bad++; $display("FAIL idle_full_wait got=level %0d want=8", q_level); end
        flush = 1'b1; flush_addr = 20'h12345;
        step();
        flush = 1'b0;
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL fidle_valid got=%h want=0", q_valid); end
        total++; if (q_addr !== 20'h12345) begin bad++; $display("FAIL fidle_q_addr got=%h want=12345", q_addr); end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fidle_req got=%h want=1", mem_req); end
        total++; if (mem_addr !== 20'h12345) begin bad++; $display("FAIL fidle_mem_addr got=%h want=12345", mem_addr); end
        total++; if (q_level !== 4'd0) begin bad++; $display("FAIL fidle_level got=%0d want=0", q_level); end
        step();
        total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL fidle_first_valid got=%h want=1", q_valid); end
        total++; if (q_data !== 8'h45) begin bad++; $display("FAIL fidle_first_data got=%h want=45", q_data); end
        total++; if (q_addr !== 20'h12345) begin bad++; $display("FAIL fidle_first_addr got=%h want=12345", q_addr); end
    endtask

    task automatic test_flush_mid();
        int n;
        ack_mode = 2;
        mem_ack = 1'b0;
        step();
        flush = 1'b1; flush_addr = 20'h00050;
        step();
        flush = 1'b0;
        n = 0;
        while (mem_addr != 20'h00050 && n < 4) begin
            mem_ack = 1'b1; mem_data = 8'hAA;
            step();
            mem_ack = 1'b0;
            n++;
        end
        total++; if (mem_addr !== 20'h00050 || mem_req !== 1'b1) begin bad++; $display("FAIL mid_setup got=%h/%h want=00050/1", mem_addr, mem_req); end
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL mid_drained_valid got=%h want=0", q_valid); end
        flush = 1'b1; flush_addr = 20'h00100;
        step();
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL mid1_valid got=%h want=0", q_valid); end
        total++; if (q_addr !== 20'h00100) begin bad++; $display("FAIL mid1_q_addr got=%h want=00100", q_addr); end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mid1_req got=%h want=1", mem_req); end
        total++; if (mem_addr !== 20'h00050) begin bad++; $display("FAIL mid1_mem_addr got=%h want=00050", mem_addr); end
        flush_addr = 20'h00200;
        step();
        flush = 1'b0;
        total++; if (q_addr !== 20'h00200) begin bad++; $display("FAIL mid2_q_addr got=%h want=00200", q_addr); end
        total++; if (mem_addr !== 20'h00050) begin bad++; $display("FAIL mid2_mem_addr got=%h want=00050", mem_addr); end
        step();
        total++; if (mem_req !== 1'b1 || mem_addr !== 20'h00050) begin bad++; $display("FAIL mid3_hold got=%h/%h want=1/00050", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_data = 8'h5A;
        step();
        mem_ack = 1'b0;
        total++; if (mem_addr !== 20'h00200) begin bad++; $display("FAIL mid_new_addr got=%h want=00200", mem_addr); end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_new_req got=%h want=1", mem_req); end
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL mid_old_dropped got=%h want=0", q_valid); end
        total++; if (q_level !== 4'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", q_level); end
        mem_ack = 1'b1; mem_data = 8'hC3;
        step();
        mem_ack = 1'b0;
        total++; if (q_valid !== 1'b1 || q_data !== 8'hC3) begin bad++; $display("FAIL mid_first_byte got=%h/%h want=1/c3", q_valid, q_data); end
        total++; if (mem_addr !== 20'h00201) begin bad++; $display("FAIL mid_next_addr got=%h want=00201", mem_addr); end
    endtask

    task automatic test_flush_ack();
        mem_ack = 1'b1; mem_data = 8'h77;
        flush = 1'b1; flush_addr = 20'h0ABCD;
        step();
        mem_ack = 1'b0; flush = 1'b0;
        total++; if (mem_addr !== 20'h0ABCD) begin bad++; $display("FAIL fack_mem_addr got=%h want=0abcd", mem_addr); end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fack_req got=%h want=1", mem_req); end
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL fack_valid got=%h want=0", q_valid); end
        total++; if (q_level !== 4'd0) begin bad++; $display("FAIL fack_level got=%0d want=0", q_level); end
        total++; if (q_addr !== 20'h0ABCD) begin bad++; $display("FAIL fack_q_addr got=%h want=0abcd", q_addr); end
        mem_ack = 1'b1; mem_data = 8'hCD;
        step();
        mem_ack = 1'b0;
        total++; if (q_valid !== 1'b1 || q_data !== 8'hCD) begin bad++; $display("FAIL fack_first got=%h/%h want=1/cd", q_valid, q_data); end
        total++; if (mem_addr !== 20'h0ABCE) begin bad++; $display("FAIL fack_next_addr got=%h want=0abce", mem_addr); end
    endtask

    task automatic test_random();
        logic        prev_req, prev_ack, prev_flush, take;
        logic [19:0] prev_addr;
        logic [31:0] fa;
        logic [7:0]  exp;
        mix_en = 1'b1;
        ack_mode = 1;
        flush = 1'b1; flush_addr = 20'hFFFF8;
        exp_addr = 20'hFFFF8;
        sb.delete();
        prev_req = 1'b0; prev_ack = 1'b0; prev_flush = 1'b1; prev_addr = '0;
        for (int i = 0; i < 800; i++) begin
            step();
            #1;
            flush = 1'b0; q_take = 1'b0;
            total++; if (q_level > 4'(DEPTH)) begin bad++; $display("FAIL rnd_level[%0d] got=%0d want<=%0d", i, q_level, DEPTH); end
            total++; if (q_addr !== exp_addr) begin bad++; $display("FAIL rnd_q_addr[%0d] got=%h want=%h", i, q_addr, exp_addr); end
            if (prev_flush) begin
                total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL rnd_flush_valid[%0d] got=%h want=0", i, q_valid); end
            end
            if (prev_req && !prev_ack) begin
                total++; if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin bad++; $display("FAIL rnd_req_hold[%0d] got=%h/%h want=1/%h", i, mem_req, mem_addr, prev_addr); end
            end
            prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
            prev_flush = 1'b0;
            if ($urandom_range(0, 29) == 0) begin
                fa = $urandom;
                if ($urandom_range(0, 1) == 1) fa[19:4] = 16'hFFFF;
                flush = 1'b1; flush_addr = fa[19:0];
                q_take = 1'($urandom_range(0, 1));
                exp_addr = fa[19:0];
                prev_flush = 1'b1;
            end else begin
                take = 1'($urandom_range(0, 2) != 0);
                q_take = take;
                if (take && q_valid) begin
                    sb.push_back(memf(exp_addr));
                    exp = sb.pop_front();
                    total++; if (q_data !== exp) begin bad++; $display("FAIL rnd_data[%0d] @%h got=%h want=%h", i, exp_addr, q_data, exp); end
                    exp_addr = exp_addr + 20'd1;
                end
            end
        end
        step();
        flush = 1'b0; q_take = 1'b0;
    endtask

    task automatic test_async_reset();
        ack_mode = 0;
        step(); step();
        #7;
        reset = 1'b1;
        #3;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL arst_req got=%h want=0", mem_req); end
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%h want=0", q_valid); end
        total++; if (mem_addr !== 20'hFFFF0 || q_addr !== 20'hFFFF0) begin bad++; $display("FAIL arst_addr got=%h/%h want=ffff0", mem_addr, q_addr); end
        step();
        reset = 1'b0;
        step();
        total++; if (mem_req !== 1'b1 || mem_addr !== 20'hFFFF0) begin bad++; $display("FAIL arst_restart got=%h/%h want=1/ffff0", mem_req, mem_addr); end
    endtask

    initial begin : main
        reset = 1'b1;
        test_reset();
        test_reset_fetch();
        test_stream();
        test_flush_idle();
        test_flush_mid();
        test_flush_ack();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
